// File: rtl/dmem_mmio_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_mmio_ctrl
//
// Data-side memory controller that sits directly on the core's data port.
// It decodes an 11-bit byte address into a word-organised data RAM
// (addr[10]=0) or a small MMIO window (addr[10]=1). The MMIO window holds:
//   0x400 GPIO_OUT (RW)   0x404 CYCLE (RO)
//   0x408 TX_DATA  (WO)   0x40C STATUS (R, W1C on bits 2/3)
// Sub-word stores are lane-steered here. Loads always return the full aligned
// word, combinationally and read-before-write; the core's writeback extracts
// and sign-extends bytes/halves.
//
// Ports:
//   i_clk, i_rst_n   clock (rising edge), asynchronous active-low reset
//   i_dmem_we        store enable for the current cycle
//   i_dmem_addr      byte address
//   i_dmem_wdata     unshifted store data (rs2)
//   i_dmem_f3        funct3: 000 SB, 001 SH, 010 SW, others = no store
//   o_dmem_rdata     aligned word at addr[10:2] (combinational)
//   o_gpio           GPIO_OUT register
//   o_tx_valid       TX FIFO not empty
//   o_tx_data        TX FIFO head byte (0 when empty)
//   i_tx_ready       consumer takes the head byte when o_tx_valid is high
// -----------------------------------------------------------------------------
module dmem_mmio_ctrl #(
    parameter int P_DATA_WIDTH      = 32,
    parameter int P_DMEM_ADDR_WIDTH = 11,
    parameter int P_TX_DEPTH        = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_dmem_we,
    input  logic [P_DMEM_ADDR_WIDTH-1:0] i_dmem_addr,
    input  logic [P_DATA_WIDTH-1:0]      i_dmem_wdata,
    input  logic [2:0]                   i_dmem_f3,
    output logic [P_DATA_WIDTH-1:0]      o_dmem_rdata,
    output logic [P_DATA_WIDTH-1:0]      o_gpio,
    output logic                         o_tx_valid,
    output logic [7:0]                   o_tx_data,
    input  logic                         i_tx_ready
);

    localparam int RAM_WORDS = 1 << (P_DMEM_ADDR_WIDTH - 3);
    localparam int PTR_W     = $clog2(P_TX_DEPTH);
    localparam int CNT_W     = PTR_W + 1;

    // ------------------------------------------------------------------ decode
    logic                         mmio_sel;
    logic [2:0]                   reg_idx;
    logic [1:0]                   off;
    logic [P_DMEM_ADDR_WIDTH-4:0] ram_idx;

    assign mmio_sel = i_dmem_addr[P_DMEM_ADDR_WIDTH-1];
    assign reg_idx  = i_dmem_addr[4:2];
    assign off      = i_dmem_addr[1:0];
    assign ram_idx  = i_dmem_addr[P_DMEM_ADDR_WIDTH-2:2];

    // Lane steering: replicate the store data across the word so each lane
    // simply takes its own byte; lane_en picks which lanes actually commit.
    logic [3:0]              lane_en;
    logic [P_DATA_WIDTH-1:0] store_data;
    logic                    misalign_set;

    always_comb begin
        lane_en      = 4'b0000;
        store_data   = '0;
        misalign_set = 1'b0;
        if (i_dmem_we) begin
            case (i_dmem_f3)
                3'b000: begin
                    store_data = {4{i_dmem_wdata[7:0]}};
                    lane_en    = 4'b0001 << off;
                end
                3'b001: begin
                    store_data = {2{i_dmem_wdata[15:0]}};
                    if (off[0]) misalign_set = 1'b1;
                    else        lane_en      = off[1] ? 4'b1100 : 4'b0011;
                end
                3'b010: begin
                    store_data = i_dmem_wdata;
                    if (off != 2'd0) misalign_set = 1'b1;
                    else             lane_en      = 4'b1111;
                end
                default: ;
            endcase
        end
    end

    logic [3:0] ram_lane_we;
    logic [3:0] gpio_lane_we;
    logic       push_req;
    logic       clr_req;

    assign ram_lane_we  = mmio_sel ? 4'b0000 : lane_en;
    assign gpio_lane_we = (mmio_sel && reg_idx == 3'd0) ? lane_en : 4'b0000;
    assign push_req     = mmio_sel && reg_idx == 3'd2 && lane_en[0];
    assign clr_req      = mmio_sel && reg_idx == 3'd3 && lane_en[0];

    // --------------------------------------------------------------- data RAM
    // One byte-wide array per lane so every lane is an independent memory
    // with its own write enable. Contents are intentionally not reset.
    logic [P_DATA_WIDTH-1:0] ram_rdata;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] ram_lane [0:RAM_WORDS-1];

            always_ff @(posedge i_clk) begin
                if (ram_lane_we[gi])
                    ram_lane[ram_idx] <= store_data[gi*8 +: 8];
            end

            assign ram_rdata[gi*8 +: 8] = ram_lane[ram_idx];
        end
    endgenerate

    // ---------------------------------------------------------- MMIO registers
    logic [P_DATA_WIDTH-1:0] gpio_reg;
    logic [P_DATA_WIDTH-1:0] cycle_reg;
    logic                    ovf_reg;
    logic                    misalign_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            gpio_reg  <= '0;
            cycle_reg <= '0;
        end else begin
            cycle_reg <= cycle_reg + 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (gpio_lane_we[i])
                    gpio_reg[i*8 +: 8] <= store_data[i*8 +: 8];
            end
        end
    end

    // ---------------------------------------------------------------- TX FIFO
    logic [7:0]       tx_mem [0:P_TX_DEPTH-1];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             full;
    logic             empty;
    logic             pop;
    logic             push_ok;
    logic             ovf_set;

    assign full  = (count_reg == CNT_W'(P_TX_DEPTH));
    assign empty = (count_reg == '0);
    assign pop   = !empty && i_tx_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // still lands when the consumer is draining.
    assign push_ok = push_req && (!full || pop);
    assign ovf_set = push_req && full && !pop;

    always_ff @(posedge i_clk) begin
        if (push_ok)
            tx_mem[wr_ptr_reg] <= store_data[7:0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: ;
            endcase
        end
    end

    // Sticky flags: write-1-to-clear through STATUS lane 0, a simultaneous
    // set event takes priority over the clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ovf_reg      <= 1'b0;
            misalign_reg <= 1'b0;
        end else begin
            ovf_reg      <= (ovf_reg & ~(clr_req & store_data[2])) | ovf_set;
            misalign_reg <= (misalign_reg & ~(clr_req & store_data[3])) | misalign_set;
        end
    end

    // --------------------------------------------------------------- read path
    logic [P_DATA_WIDTH-1:0] status_word;

    assign status_word = {{(P_DATA_WIDTH-8){1'b0}}, 4'(count_reg),
                          misalign_reg, ovf_reg, empty, full};

    always_comb begin
        o_dmem_rdata = '0;
        if (!mmio_sel) begin
            o_dmem_rdata = ram_rdata;
        end else begin
            case (reg_idx)
                3'd0:    o_dmem_rdata = gpio_reg;
                3'd1:    o_dmem_rdata = cycle_reg;
                3'd3:    o_dmem_rdata = status_word;
                default: o_dmem_rdata = '0;
            endcase
        end
    end

    assign o_gpio     = gpio_reg;
    assign o_tx_valid = !empty;
    assign o_tx_data  = empty ? 8'h00 : tx_mem[rd_ptr_reg];

endmodule

// File: tb/tb_dmem_mmio_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_mmio_ctrl
//
// Scoreboard bench for dmem_mmio_ctrl. The stimulus updates a behavioural
// model (byte-addressed RAM image, GPIO word, sticky flags and a queue of
// bytes the TX port must deliver). A separate monitor pops the TX queue every
// time the DUT hands over a byte and compares it. Register/RAM reads are
// compared against the model or against fixed expected constants.
// -----------------------------------------------------------------------------
module tb_dmem_mmio_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [10:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [2:0]  f3 = '0;
    logic        tx_ready = 1'b0;
    logic [31:0] rdata;
    logic [31:0] gpio;
    logic        tx_valid;
    logic [7:0]  tx_data;

    int checks = 0;
    int errors = 0;

    // behavioural model
    logic [31:0] ram_m [256];
    logic [31:0] gpio_m = '0;
    logic        ovf_m = 1'b0;
    logic        mis_m = 1'b0;
    logic [7:0]  txq [$];

    dmem_mmio_ctrl dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_dmem_we    (we),
        .i_dmem_addr  (addr),
        .i_dmem_wdata (wdata),
        .i_dmem_f3    (f3),
        .o_dmem_rdata (rdata),
        .o_gpio       (gpio),
        .o_tx_valid   (tx_valid),
        .o_tx_data    (tx_data),
        .i_tx_ready   (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    function automatic logic [31:0] model_status();
        int n;
        n = txq.size();
        return {24'h0, 4'(n), mis_m, ovf_m, (n == 0), (n == 4)};
    endfunction

    // Apply one store to the model using byte-level rules.
    task automatic model_store(input logic [10:0] a, input logic [31:0] d,
                               input logic [2:0] fn, input logic rdy);
        int off, nb, lane;
        logic [7:0] b;
        off = int'(a[1:0]);
        if (fn > 3'd2) return;
        if ((fn == 3'd1 && (off % 2) != 0) || (fn == 3'd2 && off != 0)) begin
            mis_m = 1'b1;
            return;
        end
        nb = (fn == 3'd0) ? 1 : (fn == 3'd1) ? 2 : 4;
        for (int i = 0; i < nb; i++) begin
            lane = off + i;
            b    = d[8*i +: 8];
            if (!a[10]) begin
                ram_m[a[9:2]][8*lane +: 8] = b;
            end else begin
                case (a[4:2])
                    3'd0: gpio_m[8*lane +: 8] = b;
                    3'd2: if (lane == 0) begin
                        if (txq.size() < 4 || (rdy && txq.size() > 0)) txq.push_back(b);
                        else ovf_m = 1'b1;
                    end
                    3'd3: if (lane == 0) begin
                        if (b[3]) mis_m = 1'b0;
                        if (b[2]) ovf_m = 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    endtask

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic store(input logic [10:0] a, input logic [31:0] d, input logic [2:0] fn);
        model_store(a, d, fn, tx_ready);
        we = 1'b1; addr = a; wdata = d; f3 = fn;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic rd(input string name, input logic [10:0] a, input logic [31:0] exp);
        we = 1'b0; addr = a;
        @(negedge clk);
        chk(name, rdata, exp);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // TX monitor: every accepted byte must be the oldest one the model expects.
    always @(negedge clk) begin
        if (rst_n && tx_valid && tx_ready) begin
            logic [7:0] e;
            checks++;
            if (txq.size() == 0) begin
                errors++;
                $display("FAIL tx_pop: got 0x%02h expected no byte", tx_data);
            end else begin
                e = txq.pop_front();
                if (tx_data !== e) begin
                    errors++;
                    $display("FAIL tx_pop: got 0x%02h expected 0x%02h", tx_data, e);
                end else begin
                    $display("ok   tx_pop: 0x%02h", tx_data);
                end
            end
        end
    end

    initial begin
        logic [31:0] a0, a1, w20;
        logic [10:0] ra;
        logic [2:0]  fn;
        int r;

        // ---- reset state
        idle(3);
        chk("rst_gpio", gpio, 32'h0);
        chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
        rst_n = 1'b1;
        rd("rst_status", 11'h40C, 32'h0000_0002);

        // preload RAM so every word has a known value
        for (int i = 0; i < 256; i++) store(11'(i * 4), $urandom, 3'b010);

        // ---- 1: lane steering
        store(11'h010, 32'h1234_5678, 3'b010);
        store(11'h012, 32'h7777_77AB, 3'b000);
        rd("t1_sb", 11'h010, 32'h12AB_5678);
        store(11'h012, 32'h1234_BEEF, 3'b001);
        rd("t1_sh", 11'h010, 32'hBEEF_5678);

        // ---- 2: misaligned and invalid-f3 stores
        w20 = ram_m[8];
        store(11'h013, 32'hDEAD_BEEF, 3'b001);
        store(11'h022, 32'hCAFE_F00D, 3'b010);
        rd("t2_ram010", 11'h010, 32'hBEEF_5678);
        rd("t2_ram020", 11'h020, w20);
        rd("t2_status_mis", 11'h40C, 32'h0000_000A);
        store(11'h40C, 32'h0000_0008, 3'b010);
        rd("t2_status_clr", 11'h40C, 32'h0000_0002);
        store(11'h010, 32'h0, 3'b011);
        rd("t2_f3_ignored", 11'h010, 32'hBEEF_5678);
        rd("t2_f3_noflag", 11'h40C, 32'h0000_0002);

        // ---- 3: overflow then drain
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) store(11'h408, 32'h41 + 32'(i), 3'b000);
        rd("t3_status_full", 11'h40C, 32'h0000_0045);
        tx_ready = 1'b1;
        idle(3);
        @(negedge clk);
        chk("t3_valid_before_last", {31'h0, tx_valid}, 32'h1);
        @(posedge clk); #1;
        tx_ready = 1'b0;
        @(negedge clk);
        chk("t3_valid_after_last", {31'h0, tx_valid}, 32'h0);
        @(posedge clk); #1;
        chk("t3_sb_drained", 32'(txq.size()), 32'h0);
        store(11'h40C, 32'h0000_0004, 3'b010);
        rd("t3_status_clr", 11'h40C, 32'h0000_0002);

        // ---- 4: push and pop together while full
        for (int i = 0; i < 4; i++) store(11'h408, 32'h31 + 32'(i), 3'b000);
        rd("t4_status_full", 11'h40C, 32'h0000_0041);
        tx_ready = 1'b1;
        store(11'h408, 32'h0000_0050, 3'b000);
        tx_ready = 1'b0;
        rd("t4_status_same", 11'h40C, 32'h0000_0041);
        tx_ready = 1'b1;
        idle(4);
        tx_ready = 1'b0;
        chk("t4_sb_drained", 32'(txq.size()), 32'h0);
        rd("t4_status_empty", 11'h40C, 32'h0000_0002);

        // ---- 5: GPIO lanes and cycle counter
        store(11'h400, 32'hFFFF_FFFF, 3'b010);
        store(11'h401, 32'h0000_0000, 3'b000);
        chk("t5_gpio_pin", gpio, 32'hFFFF_00FF);
        rd("t5_gpio_read", 11'h400, 32'hFFFF_00FF);
        addr = 11'h404;
        @(negedge clk); a0 = rdata;
        @(posedge clk); #1;
        @(negedge clk); a1 = rdata;
        @(posedge clk); #1;
        chk("t5_cycle_step", a1, a0 + 32'd1);
        store(11'h404, 32'h0, 3'b010);
        rd("t5_tx_reads_zero", 11'h408, 32'h0);
        rd("t5_hole_reads_zero", 11'h410, 32'h0);

        // ---- random RAM/GPIO traffic
        for (int it = 0; it < 400; it++) begin
            r = int'($urandom % 10);
            if (r < 6) begin
                ra = ($urandom % 8 == 0) ? (11'h400 | 11'($urandom % 4)) : {1'b0, 10'($urandom)};
                fn = ($urandom % 8 < 6) ? 3'($urandom % 3) : 3'($urandom_range(3, 7));
                store(ra, $urandom, fn);
            end else begin
                ra = {1'b0, 10'($urandom)};
                rd("rnd_ram", ra, ram_m[ra[9:2]]);
            end
        end
        chk("rnd_gpio", gpio, gpio_m);
        rd("rnd_status", 11'h40C, model_status());
        store(11'h40C, 32'h0000_000C, 3'b000);
        rd("rnd_status_clr", 11'h40C, model_status());

        // ---- random TX traffic
        for (int it = 0; it < 300; it++) begin
            tx_ready = 1'($urandom % 2);
            r = int'($urandom % 5);
            if (r < 2)       store(11'h408, $urandom, 3'($urandom % 3));
            else if (r == 2) store(11'h409 + 11'($urandom % 3), $urandom, 3'b000);
            else if (r == 3) idle(1);
            else begin
                tx_ready = 1'b0;
                rd("rnd_tx_status", 11'h40C, model_status());
            end
        end
        tx_ready = 1'b0;
        rd("rnd_tx_status_end", 11'h40C, model_status());
        store(11'h40C, 32'h0000_000C, 3'b010);
        tx_ready = 1'b1;
        idle(6);
        tx_ready = 1'b0;
        chk("rnd_tx_drained", 32'(txq.size()), 32'h0);
        rd("rnd_tx_status_empty", 11'h40C, 32'h0000_0002);

        // ---- 6: asynchronous reset with FIFO occupied
        store(11'h408, 32'h61, 3'b000);
        store(11'h408, 32'h62, 3'b000);
        rd("t6_status_two", 11'h40C, 32'h0000_0020);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", {31'h0, tx_valid}, 32'h0);
        chk("t6_async_gpio", gpio, 32'h0);
        chk("t6_async_data", {24'h0, tx_data}, 32'h0);
        txq.delete();
        gpio_m = '0; ovf_m = 1'b0; mis_m = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd("t6_status_after", 11'h40C, 32'h0000_0002);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_mmio_ctrl.md
Name: dmem_mmio_ctrl

Overview:
Data-side memory controller connected directly to the core's data memory port (we/addr/wdata/f3 in, rdata out). It decodes the 11-bit byte address into a word-organised data RAM and a small MMIO window. The MMIO window holds a GPIO output register, a free-running cycle counter and a byte-wide TX FIFO with a valid/ready drain port. Sub-word stores are lane-steered here. Loads always return the full aligned word; the core's writeback performs byte/half extraction and sign extension.

Parameters:
P_DATA_WIDTH, 32, data word width; only 32 is supported.
P_DMEM_ADDR_WIDTH, 11, byte address width; MSB selects RAM (0) or MMIO (1).
P_TX_DEPTH, 4, TX FIFO entries; must be a power of 2, at least 2.

Ports:
i_clk  in  1  clock, rising edge.
i_rst_n  in  1  asynchronous active-low reset.
i_dmem_we  in  1  store enable for the current cycle.
i_dmem_addr  in  P_DMEM_ADDR_WIDTH  byte address.
i_dmem_wdata  in  32  unshifted store data (rs2 value).
i_dmem_f3  in  3  funct3: 000 SB, 001 SH, 010 SW; other values mean no store.
o_dmem_rdata  out  32  aligned word at addr[10:2]; combinational.
o_gpio  out  32  GPIO_OUT register.
o_tx_valid  out  1  TX FIFO not empty.
o_tx_data  out  8  TX FIFO head byte.
i_tx_ready  in  1  consumer accepts the head byte when o_tx_valid is high.

Behaviour:
- Reset is asynchronous, active-low, on i_rst_n.
  - Reset clears GPIO_OUT, CYCLE, FIFO pointers and count, the overflow flag and the misalign flag.
  - After reset: o_gpio=0, o_tx_valid=0, o_tx_data=0.
  - RAM contents are not reset.
- Address map:
  - addr[10]=0 selects RAM: 256 words, index addr[9:2].
  - addr[10]=1 selects MMIO, register index addr[4:2]. 0x400 GPIO_OUT (RW). 0x404 CYCLE (RO). 0x408 TX_DATA (WO, reads return 0). 0x40C STATUS.
  - Other MMIO offsets read 0; writes to them are ignored.
- Reads: combinational, zero latency. o_dmem_rdata reflects the state before any same-cycle write (read-before-write).
- Byte-lane steering on stores, with off=addr[1:0]:
  - SB: byte off gets wdata[7:0].
  - SH: off=0 writes lanes 1:0; off=2 writes lanes 3:2; data is wdata[15:0].
  - SW: off=0 writes all lanes.
  - Writes apply at the clock edge with we=1. Unselected lanes keep their value.
- Misaligned stores: SH with off odd, or SW with off!=0.
  - No write occurs anywhere.
  - The sticky misalign flag is set.
- f3 not in {000,001,010} with we=1: the store is ignored and no flag is set.
- GPIO_OUT: honours lane enables, so a byte store updates only its byte.
- CYCLE: 32-bit counter, increments every cycle, wraps from 0xFFFFFFFF to 0. Writes are ignored.
- TX_DATA store (any valid size, lane 0 enabled) pushes wdata[7:0].
  - A store to 0x409..0x40B does not push, since lane 0 is not enabled.
  - If the FIFO is full and no pop happens the same cycle, the push is dropped and the sticky overflow flag is set.
  - Push and pop in the same cycle when full: both happen, count unchanged, no overflow.
  - Pop occurs on o_tx_valid & i_tx_ready.
  - Pointers wrap modulo P_TX_DEPTH.
  - o_tx_data shows the head entry whenever the FIFO is not empty.
- STATUS read layout: bit0 full, bit1 empty, bit2 overflow, bit3 misalign, bits[7:4] count (0..P_TX_DEPTH), rest 0.
  - A word or byte store to STATUS is write-1-to-clear on bits 2 and 3 (lane 0 only).
  - A clear and a new set event in the same cycle: set wins.
- Reset asserted mid-operation: pending stores are lost and the FIFO is emptied immediately (asynchronously).

Test Plan:
1. Reset, then SW 0x12345678 to 0x010, then SB 0xAB to 0x012 -> read of 0x010 = 0x12AB5678; SH 0xBEEF to 0x012 -> read = 0xBEEF5678.
2. SH to 0x013 and SW to 0x022 -> RAM unchanged, STATUS bit3=1; SW 0x8 to 0x40C -> bit3=0.
3. Hold i_tx_ready=0 and push 0x41,0x42,0x43,0x44,0x45 -> STATUS = full, count=4, overflow=1; drain with ready=1 -> bytes 0x41..0x44 in order, o_tx_valid falls after the 4th.
4. FIFO full with i_tx_ready=1, push 0x50 in the same cycle -> count stays 4, overflow stays 0, 0x50 emerges last.
5. SW 0xFFFFFFFF to 0x400, then SB 0x00 to 0x401 -> o_gpio = 0xFFFF00FF; read 0x404 on two consecutive cycles -> values differ by 1.
6. Assert i_rst_n=0 asynchronously while the FIFO holds 2 entries -> o_tx_valid=0 and o_gpio=0 before the next edge; STATUS = empty, count=0 after release.
